hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage CPU. It watches the ID and EX stages and drives the pause/flush controls of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It covers three cases: a 1-cycle load-use bubble, the branch-taken squash, and a multi-cycle stall for the iterative mul/div unit. A small FSM tracks the mul/div wait.

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage CPU.
// Drives pause/flush for PC, IF/ID, ID/EX and EX/MEM. It handles three cases:
//   - the load-use bubble,
//   - the branch-taken squash,
//   - the multi-cycle mul/div stall.
// Optional build macro HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_count performance counters.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 32  // total stall cycles per mul/div op, 2..64
) (
  input  logic       clk,
  input  logic       resetn,            // asynchronous, active-high
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  output logic       pc_pause,
  output logic       if_id_pause,
  output logic       if_id_flush,
  output logic       id_ex_pause,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  localparam logic [5:0] MdLoad = 6'(MD_LATENCY - 1);

  logic [0:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       load_use;

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_memread && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Output decode and next state; priority is md start, branch, load-use.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_pause  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (state_q == MD_WAIT) begin
      // EX holds the mul/div op; everything else is ignored.
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_flush = 1'b1;
      md_busy      = 1'b1;
      cnt_d        = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        md_done = 1'b1;
        state_d = RUN;
      end
    end else if (ex_md_start) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = MD_WAIT;
      cnt_d        = MdLoad;
    end else if (ex_branch_taken) begin
      // The dependent instruction is squashed, so any load-use stall is dropped.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_pause    = 1'b1;
      if_id_pause = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // FSM state and mul/div countdown; reset aborts any wait immediately.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running, wrapping event counters.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (pc_pause)    stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl, with a cycle-timeline
// model checked on every falling edge plus hand-computed literal checks.
module tb_hazard_ctrl;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic       ex_branch_taken = 1'b0, ex_md_start = 1'b0;
  logic       pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush;
  logic       ex_mem_flush, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .pc_pause        (pc_pause),
    .if_id_pause     (if_id_pause),
    .if_id_flush     (if_id_flush),
    .id_ex_pause     (id_ex_pause),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .md_busy         (md_busy),
    .md_done         (md_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Output bundle: {pc_pause, if_id_pause, if_id_flush, id_ex_pause,
  //                 id_ex_flush, ex_mem_flush, md_busy, md_done}
  function automatic logic [7:0] outs();
    return {pc_pause, if_id_pause, if_id_flush, id_ex_pause,
            id_ex_flush, ex_mem_flush, md_busy, md_done};
  endfunction

  // Model: the wait is the L-1 cycles after the cycle an op started in.
  int          cyc = 0;
  int          md_start_cyc = -1000;
  int unsigned m_stall = 0, m_flush = 0;

  always @(negedge clk) begin
    int          k;
    bit          in_wait, lu;
    logic [7:0]  exp;
    if (resetn) begin
      md_start_cyc = -1000;
      m_stall = 0;
      m_flush = 0;
    end
    k       = cyc - md_start_cyc;
    in_wait = (k >= 1) && (k <= L - 1);
    lu      = ex_memread && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (in_wait)              exp = 8'b1101_0110 | {7'd0, k == L - 1};
    else if (ex_md_start)     exp = 8'b1101_0100;
    else if (ex_branch_taken) exp = 8'b0010_1000;
    else if (lu)              exp = 8'b1100_1000;
    else                      exp = 8'b0000_0000;
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL model_outs cyc=%0d got=%b want=%b", cyc, outs(), exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cycles !== m_stall || flush_count !== m_flush) begin
      miscompares++;
      $display("FAIL model_perf cyc=%0d got=%0d/%0d want=%0d/%0d",
               cyc, stall_cycles, flush_count, m_stall, m_flush);
    end
`endif
    if (!resetn) begin
      if (!in_wait && ex_md_start) md_start_cyc = cyc;
      if (exp[7]) m_stall++;
      if (exp[5]) m_flush++;
    end
    cyc++;
  end

  // Apply one cycle of inputs just after the rising edge.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic bt, input logic ms);
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_rd = rd; ex_branch_taken = bt; ex_md_start = ms;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Literal check, sampled mid-way between the input change and the falling edge.
  task automatic lit(input string name, input logic [7:0] want);
    #2;
    vectors++;
    if (outs() !== want) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", name, outs(), want);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("reset_idle", 8'b0000_0000);
    @(posedge clk); #1 resetn = 1'b0;
    lit("first_cycle_after_reset", 8'b0000_0000);

    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    lit("load_use_rs1", 8'b1100_1000);
    idle();
    lit("load_use_no_repeat", 8'b0000_0000);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    lit("rd_zero_no_stall", 8'b0000_0000);
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    lit("rs1_unused_no_stall", 8'b0000_0000);
    drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    lit("load_use_rs2", 8'b1100_1000);
    drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
    lit("not_a_load", 8'b0000_0000);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    lit("branch_over_load_use", 8'b0010_1000);

    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    lit("md_start_wins", 8'b1101_0100);
    idle();
    lit("md_wait1", 8'b1101_0110);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    lit("md_wait2_ignores", 8'b1101_0110);
    idle();
    lit("md_wait3_done", 8'b1101_0111);
    idle();
    lit("md_after_done", 8'b0000_0000);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    lit("md2_start", 8'b1101_0100);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    lit("md2_branch_ignored", 8'b1101_0110);
    idle();
    #1 resetn = 1'b1;
    lit("reset_aborts_wait", 8'b0000_0000);
    @(posedge clk); #1 resetn = 1'b0;
    lit("run_after_abort", 8'b0000_0000);

    // One load-use, one branch and one mul/div op from cleared counters.
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1 resetn = 1'b0;
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    repeat (L) idle();
    #2;
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cycles !== 32'd5) begin
      miscompares++;
      $display("FAIL perf_stall got=%0d want=5", stall_cycles);
    end
    vectors++;
    if (flush_count !== 32'd1) begin
      miscompares++;
      $display("FAIL perf_flush got=%0d want=1", flush_count);
    end
`endif
    lit("final_idle", 8'b0000_0000);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
